// File: rtl/stage_e_pkg.sv
// rtl/stage_e_pkg.sv - cpu_defs: exception codes, PCs and field layouts shared by the pipeline stages
package cpu_defs;

  localparam int EXC_WIDTH = 5;
  localparam int CTRL_W    = 16;
  localparam int TNEW_W    = 2;

  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] PC_HANDLER = 32'h0000_4180;

  typedef enum logic [EXC_WIDTH-1:0] {
    EXC_INT     = 5'd0,
    EXC_ADEL    = 5'd4,
    EXC_ADES    = 5'd5,
    EXC_SYSCALL = 5'd8,
    EXC_RI      = 5'd10,
    EXC_OV      = 5'd12
  } exc_code_e;

  // Fields that are zeroed whenever a bubble is inserted.
  typedef struct packed {
    logic [31:0]       instr;
    logic [31:0]       rs;
    logic [31:0]       rt;
    logic [31:0]       imm;
    logic [4:0]        a1;
    logic [4:0]        a2;
    logic [4:0]        a3;
    logic [CTRL_W-1:0] ctrl;
    logic [TNEW_W-1:0] tnew;
  } e_fields_t;

  function automatic logic [TNEW_W-1:0] tnew_age(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/stage_e_if.sv
// rtl/stage_e_if.sv - D-to-E pipeline bus: decode-side inputs, control, execute-side outputs
interface stage_e_if;
  import cpu_defs::*;

  logic                 stall;
  logic                 req;
  logic                 flush;
  logic [31:0]          instr_in;
  logic [31:0]          pc_in;
  logic                 slot_in;
  logic [EXC_WIDTH-1:0] exc_in;
  logic [EXC_WIDTH-1:0] dec_exc;
  logic [31:0]          rs_val;
  logic [31:0]          rt_val;
  logic [31:0]          imm_in;
  logic [4:0]           a1_in;
  logic [4:0]           a2_in;
  logic [4:0]           a3_in;
  logic [TNEW_W-1:0]    tnew_in;
  logic [CTRL_W-1:0]    ctrl_in;

  logic [31:0]          instr_out;
  logic [31:0]          pc_out;
  logic [31:0]          rs_out;
  logic [31:0]          rt_out;
  logic [31:0]          imm_out;
  logic [4:0]           a1_out;
  logic [4:0]           a2_out;
  logic [4:0]           a3_out;
  logic [EXC_WIDTH-1:0] exc_out;
  logic                 slot_out;
  logic [TNEW_W-1:0]    tnew_out;
  logic [CTRL_W-1:0]    ctrl_out;
  logic                 bubble_out;

  modport master (
    output stall, req, flush, instr_in, pc_in, slot_in, exc_in, dec_exc,
           rs_val, rt_val, imm_in, a1_in, a2_in, a3_in, tnew_in, ctrl_in,
    input  instr_out, pc_out, rs_out, rt_out, imm_out, a1_out, a2_out, a3_out,
           exc_out, slot_out, tnew_out, ctrl_out, bubble_out
  );

  modport slave (
    input  stall, req, flush, instr_in, pc_in, slot_in, exc_in, dec_exc,
           rs_val, rt_val, imm_in, a1_in, a2_in, a3_in, tnew_in, ctrl_in,
    output instr_out, pc_out, rs_out, rt_out, imm_out, a1_out, a2_out, a3_out,
           exc_out, slot_out, tnew_out, ctrl_out, bubble_out
  );
endinterface

// File: rtl/stage_e_pipe_field.sv
// rtl/stage_e_pipe_field.sv - pipe_field: register with priority reset > clear > load
module pipe_field #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)      q <= RST_VAL;
    else if (clr) q <= CLR_VAL;
    else          q <= d;
  end

endmodule

// File: rtl/stage_e.sv
// rtl/stage_e.sv - D/E pipeline register with bubble insertion, exception merge and Tnew aging
module stage_e
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC   = PC_RESET,
  parameter logic [31:0] HANDLER_PC = PC_HANDLER,
  parameter int          EXC_W      = EXC_WIDTH
) (
  input logic     clk,
  input logic     rst,
  stage_e_if.slave bus
);

  logic            squash;
  logic            slot_clr;
  logic [31:0]     pc_d;
  logic [EXC_W-1:0] exc_merged;
  e_fields_t       d_fields;
  e_fields_t       q_fields;

  assign squash = bus.req | bus.stall | bus.flush;
  // A stall bubble keeps the D slot flag so a later interrupt reports BD correctly.
  assign slot_clr   = bus.req | (bus.flush & ~bus.stall);
  assign pc_d       = bus.req ? HANDLER_PC : bus.pc_in;
  assign exc_merged = (bus.exc_in != '0) ? bus.exc_in : bus.dec_exc;

  always_comb begin
    d_fields       = '0;
    d_fields.instr = bus.instr_in;
    d_fields.rs    = bus.rs_val;
    d_fields.rt    = bus.rt_val;
    d_fields.imm   = bus.imm_in;
    d_fields.a1    = bus.a1_in;
    d_fields.a2    = bus.a2_in;
    d_fields.a3    = bus.a3_in;
    d_fields.ctrl  = bus.ctrl_in;
    d_fields.tnew  = tnew_age(bus.tnew_in);
  end

  pipe_field #(.W($bits(e_fields_t))) u_data (
    .clk(clk), .rst(rst), .clr(squash), .d(d_fields), .q(q_fields)
  );

  pipe_field #(.W(32), .RST_VAL(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .clr(1'b0), .d(pc_d), .q(bus.pc_out)
  );

  pipe_field #(.W(1)) u_slot (
    .clk(clk), .rst(rst), .clr(slot_clr), .d(bus.slot_in), .q(bus.slot_out)
  );

  pipe_field #(.W(EXC_W)) u_exc (
    .clk(clk), .rst(rst), .clr(squash), .d(exc_merged), .q(bus.exc_out)
  );

  pipe_field #(.W(1), .RST_VAL(1'b1), .CLR_VAL(1'b1)) u_bubble (
    .clk(clk), .rst(rst), .clr(squash), .d(1'b0), .q(bus.bubble_out)
  );

  assign bus.instr_out = q_fields.instr;
  assign bus.rs_out    = q_fields.rs;
  assign bus.rt_out    = q_fields.rt;
  assign bus.imm_out   = q_fields.imm;
  assign bus.a1_out    = q_fields.a1;
  assign bus.a2_out    = q_fields.a2;
  assign bus.a3_out    = q_fields.a3;
  assign bus.ctrl_out  = q_fields.ctrl;
  assign bus.tnew_out  = q_fields.tnew;

endmodule

// File: tb/tb_stage_e.sv
// tb/tb_stage_e.sv - randomized self-checking bench for stage_e against a behavioural model
module tb_stage_e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  stage_e_if bus();

  stage_e dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc, rs, rt, imm;
    logic [4:0]  a1, a2, a3, exc;
    logic        slot, bubble;
    logic [1:0]  tnew;
    logic [15:0] ctrl;
  } exp_t;

  exp_t exp_q;
  logic exp_v = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_chk++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req_v, $time);
    end
  endtask

  // Expected E contents follow only from the inputs present at the capturing edge.
  always @(posedge clk) begin
    exp_t e;
    int   t;
    e = '{default: '0};
    e.bubble = 1'b1;
    if (rst) e.pc = 32'h0000_3000;
    else if (bus.req) e.pc = 32'h0000_4180;
    else if (bus.stall) begin
      e.pc   = bus.pc_in;
      e.slot = bus.slot_in;
    end else if (bus.flush) e.pc = bus.pc_in;
    else begin
      e.instr = bus.instr_in; e.pc = bus.pc_in; e.rs = bus.rs_val; e.rt = bus.rt_val;
      e.imm = bus.imm_in; e.a1 = bus.a1_in; e.a2 = bus.a2_in; e.a3 = bus.a3_in;
      e.ctrl = bus.ctrl_in; e.slot = bus.slot_in; e.bubble = 1'b0;
      e.exc = (bus.exc_in != 0) ? bus.exc_in : bus.dec_exc;
      t = int'(bus.tnew_in);
      t = (t > 0) ? t - 1 : 0;
      e.tnew = t[1:0];
    end
    exp_q <= e;
    exp_v <= 1'b1;
  end

  always @(negedge clk) begin
    if (exp_v) begin
      chk("instr",  bus.instr_out, exp_q.instr);
      chk("pc",     bus.pc_out,    exp_q.pc);
      chk("rs",     bus.rs_out,    exp_q.rs);
      chk("rt",     bus.rt_out,    exp_q.rt);
      chk("imm",    bus.imm_out,   exp_q.imm);
      chk("a1",     32'(bus.a1_out), 32'(exp_q.a1));
      chk("a2",     32'(bus.a2_out), 32'(exp_q.a2));
      chk("a3",     32'(bus.a3_out), 32'(exp_q.a3));
      chk("exc",    32'(bus.exc_out), 32'(exp_q.exc));
      chk("slot",   32'(bus.slot_out), 32'(exp_q.slot));
      chk("tnew",   32'(bus.tnew_out), 32'(exp_q.tnew));
      chk("ctrl",   32'(bus.ctrl_out), 32'(exp_q.ctrl));
      chk("bubble", 32'(bus.bubble_out), 32'(exp_q.bubble));
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ctl(input logic r, input logic rq, input logic st, input logic fl);
    rst = r; bus.req = rq; bus.stall = st; bus.flush = fl;
  endtask

  task automatic set_data(input logic [31:0] instr, input logic [31:0] pc, input logic slot,
                          input logic [4:0] exc, input logic [4:0] dexc,
                          input logic [4:0] a3, input logic [1:0] tnew);
    bus.instr_in = instr; bus.pc_in = pc; bus.slot_in = slot;
    bus.exc_in = exc; bus.dec_exc = dexc; bus.a3_in = a3; bus.tnew_in = tnew;
    bus.rs_val = instr ^ 32'h5a5a_0001; bus.rt_val = pc + 32'd7; bus.imm_in = 32'h0000_0004;
    bus.a1_in = 5'd1; bus.a2_in = 5'd3; bus.ctrl_in = 16'hbeef;
  endtask

  task automatic randomize_data();
    logic [4:0] fe [3];
    logic [4:0] de [4];
    fe = '{5'd0, 5'd0, 5'd4};
    de = '{5'd0, 5'd8, 5'd10, 5'd12};
    bus.instr_in = $urandom; bus.pc_in = {$urandom_range(0, 32'h3fff), 2'b00};
    bus.slot_in = 1'($urandom); bus.exc_in = fe[$urandom_range(0, 2)];
    bus.dec_exc = de[$urandom_range(0, 3)]; bus.rs_val = $urandom; bus.rt_val = $urandom;
    bus.imm_in = $urandom; bus.a1_in = 5'($urandom); bus.a2_in = 5'($urandom);
    bus.a3_in = 5'($urandom); bus.tnew_in = 2'($urandom); bus.ctrl_in = 16'($urandom);
  endtask

  initial begin
    set_ctl(1'b1, 1'b0, 1'b0, 1'b0);
    set_data(32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd0);
    cyc(); cyc();
    chk("lit_rst_pc", bus.pc_out, 32'h0000_3000);
    chk("lit_rst_instr", bus.instr_out, 32'h0);
    chk("lit_rst_bubble", 32'(bus.bubble_out), 32'd1);
    chk("lit_rst_tnew", 32'(bus.tnew_out), 32'd0);

    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    set_data(32'h8C22_0004, 32'h3010, 1'b0, 5'd0, 5'd0, 5'd2, 2'd2);
    cyc();
    chk("lit_ld_instr", bus.instr_out, 32'h8C22_0004);
    chk("lit_ld_pc", bus.pc_out, 32'h3010);
    chk("lit_ld_tnew", 32'(bus.tnew_out), 32'd1);
    chk("lit_ld_a3", 32'(bus.a3_out), 32'd2);
    chk("lit_ld_bubble", 32'(bus.bubble_out), 32'd0);

    set_ctl(1'b0, 1'b0, 1'b1, 1'b0);
    set_data(32'h1234_5678, 32'h3024, 1'b1, 5'd4, 5'd10, 5'd9, 2'd2);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("lit_st_instr", bus.instr_out, 32'h0);
      chk("lit_st_pc", bus.pc_out, 32'h3024);
      chk("lit_st_slot", 32'(bus.slot_out), 32'd1);
      chk("lit_st_exc", 32'(bus.exc_out), 32'd0);
      chk("lit_st_bubble", 32'(bus.bubble_out), 32'd1);
    end

    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    set_data(32'h1, 32'h3028, 1'b0, 5'd4, 5'd10, 5'd0, 2'd0);
    cyc();
    chk("lit_exc_fetch", 32'(bus.exc_out), 32'd4);
    chk("lit_tnew_zero", 32'(bus.tnew_out), 32'd0);
    set_data(32'h2, 32'h302c, 1'b0, 5'd0, 5'd8, 5'd0, 2'd3);
    cyc();
    chk("lit_exc_dec", 32'(bus.exc_out), 32'd8);
    chk("lit_tnew_three", 32'(bus.tnew_out), 32'd2);

    set_ctl(1'b0, 1'b1, 1'b1, 1'b1);
    set_data(32'h3, 32'h3030, 1'b1, 5'd0, 5'd8, 5'd4, 2'd1);
    cyc();
    chk("lit_req_pc", bus.pc_out, 32'h0000_4180);
    chk("lit_req_slot", 32'(bus.slot_out), 32'd0);
    chk("lit_req_bubble", 32'(bus.bubble_out), 32'd1);
    set_ctl(1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("lit_post_req_pc", bus.pc_out, 32'h3030);
    chk("lit_post_req_bubble", 32'(bus.bubble_out), 32'd0);

    set_ctl(1'b0, 1'b0, 1'b0, 1'b1);
    set_data(32'h4, 32'h3040, 1'b1, 5'd0, 5'd10, 5'd4, 2'd1);
    cyc();
    chk("lit_fl_pc", bus.pc_out, 32'h3040);
    chk("lit_fl_slot", 32'(bus.slot_out), 32'd0);
    chk("lit_fl_exc", 32'(bus.exc_out), 32'd0);

    set_ctl(1'b1, 1'b0, 1'b1, 1'b0);
    cyc();
    chk("lit_rst_stall_pc", bus.pc_out, 32'h0000_3000);

    for (int i = 0; i < 600; i++) begin
      set_ctl(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 10),
              ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 12));
      randomize_data();
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_e.md
Name: stage_e

Overview:
- D/E pipeline register for the 5-stage MIPS core with precise exceptions.
- Captures the decoded instruction, its operands and control fields from decode, and presents them registered to the execute stage.
- Inserts bubbles on stall, squash and exception/interrupt entry.
- Merges exception codes, keeps EPC/delay-slot information valid through bubbles, and ages the hazard Tnew field.

Parameters:
- RESET_PC, 32'h0000_3000, PC held after rst.
- HANDLER_PC, 32'h0000_4180, PC held after req.
- EXC_W, 5, exception code width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hazard unit holds D; E must take a bubble
- req  in  1  CP0 exception/interrupt entry; squash E
- flush  in  1  squash the instruction leaving D (eret, etc.)
- instr_in  in  32  instruction word from D
- pc_in  in  32  PC of D instruction
- slot_in  in  1  D instruction is in a branch delay slot
- exc_in  in  5  exception carried from fetch (0 = none)
- dec_exc  in  5  exception detected by decode (RI=10, Syscall=8, 0 = none)
- rs_val  in  32  forwarded rs operand
- rt_val  in  32  forwarded rt operand
- imm_in  in  32  extended immediate
- a1_in, a2_in, a3_in  in  5 each  source/dest register numbers
- tnew_in  in  2  Tnew of D instruction, counted at D
- ctrl_in  in  16  opaque execute/mem/wb control bundle
- instr_out, pc_out, rs_out, rt_out, imm_out  out  32  registered copies
- a1_out, a2_out, a3_out  out  5  registered copies
- exc_out  out  5  merged exception code
- slot_out  out  1  delay-slot flag
- tnew_out  out  2  Tnew counted at E
- ctrl_out  out  16  registered control bundle
- bubble_out  out  1  current E content is an inserted bubble

Behaviour:
- Every output is a flop updated on posedge clk; no combinational input-to-output path. Latency is 1 cycle.
- Update priority is rst > req > stall > flush > normal.
- rst:
  - pc_out = RESET_PC.
  - All other outputs = 0, except bubble_out = 1.
- req:
  - Load a bubble.
  - pc_out = HANDLER_PC, slot_out = 0, exc_out = 0.
  - req wins over a simultaneous stall or flush.
- stall:
  - Load a bubble, but pc_out = pc_in and slot_out = slot_in.
  - Purpose: an interrupt arriving while the bubble sits in E/M reports the correct EPC/BD.
  - exc_out = 0.
- flush (without stall):
  - Load a bubble with pc_out = pc_in, slot_out = 0, exc_out = 0.
- Bubble definition:
  - instr_out = 0, rs/rt/imm = 0, a1/a2/a3 = 0, ctrl_out = 0, tnew_out = 0, bubble_out = 1.
  - A bubble never writes the register file and never raises a hazard.
- normal:
  - All fields are copied from the inputs; bubble_out = 0.
  - exc_out = (exc_in != 0) ? exc_in : dec_exc. Fetch exceptions (AdEL=4) take precedence over decode exceptions.
  - tnew_out = (tnew_in == 0) ? 0 : tnew_in - 1. Saturating; 2-bit arithmetic; never wraps to 3.
- If a3_in == 0, tnew_out is still computed as above. The hazard unit ignores register 0.
- Stall held for N cycles gives N consecutive bubbles, each carrying the same pc_in/slot_in.
- rst asserted mid-stall or mid-req gives the reset values on the next edge.
- Deasserting rst loads the normal/bubble path on the following edge.

Decomposition:
- Shared package `cpu_defs`:
  - EXC_* codes (INT=0, ADEL=4, ADES=5, SYSCALL=8, RI=10, OV=12).
  - RESET_PC/HANDLER_PC constants.
  - Widths of the ctrl bundle and tnew.
- One sub-module is natural: `pipe_field`, a parameterised-width flop with priority load/clear, instantiated once per field group.
- The merge and tnew logic stay in stage_e.

Test Plan:
- rst=1 for 2 cycles, then sample → pc_out=0x3000, instr_out=0, exc_out=0, bubble_out=1, tnew_out=0.
- Normal load with instr_in=0x8C220004, pc_in=0x3010, tnew_in=2, a3_in=2, exc_in=0, dec_exc=0 → next cycle all fields copied, tnew_out=1, bubble_out=0.
- stall=1 for 3 cycles with pc_in=0x3024, slot_in=1, instr_in nonzero → 3 cycles of instr_out=0, a3_out=0, pc_out=0x3024, slot_out=1, exc_out=0, bubble_out=1.
- Exception merge:
  - exc_in=4, dec_exc=10 → exc_out=4.
  - exc_in=0, dec_exc=8 → exc_out=8.
  - tnew_in=0 → tnew_out=0 (no wrap).
- req=1 together with stall=1 and flush=1, pc_in=0x3030 → pc_out=0x4180, slot_out=0, bubble_out=1. The next normal cycle loads inputs again.
- flush=1, stall=0, pc_in=0x3040, slot_in=1, dec_exc=10 → bubble with pc_out=0x3040, slot_out=0, exc_out=0.
